// File: rtl/edic_ctrl_pkg.sv
// Shared types and defaults for the EDiC control sequencer.
package edic_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  localparam int unsigned CTRL_W_DEF     = 21;
  localparam logic [CTRL_W_DEF-1:0] CTRL_IDLE_DEF = '1;
  localparam int unsigned FINISH_BIT_DEF = 20;

  // Bit positions inside the {V,C,Z,N} flag nibble
  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bus between instruction register / flags / decode ROM and the micro-step sequencer.
interface microcode_sequencer_if #(
  parameter int unsigned STEP_W   = 3,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned FLAG_W   = 4,
  parameter int unsigned DECODE_W = 24,
  parameter int unsigned CTRL_W   = 21
);
  localparam int unsigned ADDR_W = FLAG_W + INSTR_W + STEP_W;

  logic [INSTR_W-1:0]  i_instrCode;
  logic [FLAG_W-1:0]   i_flags;
  logic [DECODE_W-1:0] i_decodeData;
  logic                i_halt;
  logic                i_singleStep;
  logic                i_irq;
  logic                i_irqEnable;
  logic [ADDR_W-1:0]   o_decodeAddr;
  logic [CTRL_W-1:0]   o_ctrl;
  logic                o_aluSub;
  logic [1:0]          o_aluOp;
  logic                o_instrFinishedN;
  logic                o_halted;
  logic                o_irqAck;
  logic                o_fault;
  logic [STEP_W-1:0]   o_dbgStep;

  modport master (
    output i_instrCode, i_flags, i_decodeData, i_halt, i_singleStep, i_irq, i_irqEnable,
    input  o_decodeAddr, o_ctrl, o_aluSub, o_aluOp, o_instrFinishedN, o_halted,
           o_irqAck, o_fault, o_dbgStep
  );

  modport slave (
    input  i_instrCode, i_flags, i_decodeData, i_halt, i_singleStep, i_irq, i_irqEnable,
    output o_decodeAddr, o_ctrl, o_aluSub, o_aluOp, o_instrFinishedN, o_halted,
           o_irqAck, o_fault, o_dbgStep
  );

endinterface

// File: rtl/ctrl_irq_latch.sv
// Interrupt request latch: holds a pending request until the next instruction
// boundary, then marks the following instruction as the interrupt entry.
module ctrl_irq_latch (
  input  logic i_nclk,
  input  logic i_resetN,
  input  logic irq,
  input  logic irqEnable,
  input  logic boundary,
  output logic irqActive,
  output logic irqAck
);

  logic irqPending;

  always_ff @(posedge i_nclk or negedge i_resetN) begin
    if (!i_resetN) begin
      irqPending <= 1'b0;
      irqActive  <= 1'b0;
      irqAck     <= 1'b0;
    end else begin
      irqAck <= 1'b0;
      if (boundary && (irqPending || irq) && irqEnable && !irqActive) begin
        irqActive  <= 1'b1;
        irqPending <= 1'b0;
        irqAck     <= 1'b1;
      end else begin
        // The interrupt-entry instruction ends at its own boundary
        if (boundary) irqActive <= 1'b0;
        if (irq)      irqPending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-step sequencer: builds the decode ROM address from {flags, opcode, step}
// and forwards the ROM word as control strobes, with halt, single-step, IRQ and fault trap.
module microcode_sequencer
  import edic_ctrl_pkg::*;
#(
  parameter int unsigned         STEP_W     = 3,
  parameter int unsigned         INSTR_W    = 8,
  parameter int unsigned         FLAG_W     = 4,
  parameter int unsigned         DECODE_W   = 24,
  parameter int unsigned         CTRL_W     = 21,
  parameter int unsigned         FINISH_BIT = FINISH_BIT_DEF,
  parameter logic [CTRL_W-1:0]   CTRL_IDLE  = CTRL_W'(CTRL_IDLE_DEF),
  parameter logic [INSTR_W-1:0]  IRQ_OPCODE = '1,
  parameter bit                  HALT_MODE  = 1'b0
) (
  input  logic                  i_nclk,
  input  logic                  i_resetN,
  microcode_sequencer_if.slave  bus
);

  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  seq_state_t          state, stateNext;
  logic [STEP_W-1:0]   rStep, stepNext;
  logic [FLAG_W-1:0]   rFlags, flagsNext;
  logic [INSTR_W-1:0]  rInstr, instrNext;
  logic                haltPending, haltPendingNext;
  logic                inFault, finish, advance;
  logic                irqActive, irqAck;

  assign inFault = (state == FAULT);
  assign finish  = !bus.i_decodeData[FINISH_BIT] && !inFault;
  assign advance = (state == RUN) || ((state == HALT) && bus.i_singleStep);

  ctrl_irq_latch uIrqLatch (
    .i_nclk    (i_nclk),
    .i_resetN  (i_resetN),
    .irq       (bus.i_irq),
    .irqEnable (bus.i_irqEnable),
    .boundary  (finish),
    .irqActive (irqActive),
    .irqAck    (irqAck)
  );

  always_ff @(posedge i_nclk or negedge i_resetN) begin
    if (!i_resetN) begin
      state       <= RUN;
      rStep       <= '0;
      rFlags      <= '0;
      rInstr      <= '0;
      haltPending <= 1'b0;
    end else begin
      state       <= stateNext;
      rStep       <= stepNext;
      rFlags      <= flagsNext;
      rInstr      <= instrNext;
      haltPending <= haltPendingNext;
    end
  end

  // Per-edge priority: fault hold > finish > overflow > halt entry > advance
  always_comb begin
    stateNext       = state;
    stepNext        = rStep;
    flagsNext       = rFlags;
    instrNext       = rInstr;
    haltPendingNext = haltPending;

    if (HALT_MODE && (state == RUN) && bus.i_halt) haltPendingNext = 1'b1;
    if ((state == HALT) && !bus.i_halt) begin
      stateNext       = RUN;
      haltPendingNext = 1'b0;
    end

    if (inFault) begin
      stateNext = FAULT;
    end else if (finish) begin
      stepNext  = '0;
      flagsNext = '0;
      if (HALT_MODE && haltPending && (state == RUN)) stateNext = HALT;
    end else if (advance && (rStep == STEP_MAX)) begin
      stateNext = FAULT;
    end else if (!HALT_MODE && (state == RUN) && bus.i_halt) begin
      stateNext = HALT;
    end else if (advance) begin
      stepNext  = rStep + STEP_W'(1);
      flagsNext = bus.i_flags;
      instrNext = irqActive ? IRQ_OPCODE : bus.i_instrCode;
    end
  end

  assign bus.o_decodeAddr     = {rFlags, rInstr, rStep};
  assign bus.o_ctrl           = inFault ? CTRL_IDLE : bus.i_decodeData[CTRL_W-1:0];
  assign bus.o_aluSub         = rInstr[0];
  assign bus.o_aluOp          = rInstr[2:1];
  assign bus.o_instrFinishedN = inFault ? 1'b1 : bus.i_decodeData[FINISH_BIT];
  assign bus.o_halted         = (state == HALT);
  assign bus.o_irqAck         = irqAck;
  assign bus.o_fault          = inFault;
  assign bus.o_dbgStep        = rStep;

  // ROM bits above the forwarded strobes are not consumed here
  generate
    if (DECODE_W > CTRL_W) begin : gUnusedRom
      logic unusedRomBits;
      assign unusedRomBits = ^bus.i_decodeData[DECODE_W-1:CTRL_W];
    end
  endgenerate

endmodule

// File: tb/tb_microcode_sequencer.sv
// Table-driven bench for microcode_sequencer with a scoreboard queue; a behavioural
// decode ROM answers each DUT address, finishing at a programmable step.
module tb_microcode_sequencer;
  import edic_ctrl_pkg::*;

  typedef struct {
    logic       sel;
    logic       rstN, halt, step1, irq, irqEn;
    logic [3:0] fin, flg;
    logic [7:0] opc;
    logic [2:0] eStep;
    logic [3:0] eFlags;
    logic [7:0] eInstr;
    logic       eHalted, eAck, eFault;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [14:0] addr;
    logic [8:0]  status;
    logic [21:0] strobe;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] fin  = 4'd8;
  int         checks   = 0;
  int         failures = 0;
  vec_t       vecs[$];
  exp_t       sb[$];

  always #5 clk = ~clk;

  microcode_sequencer_if aIf ();
  microcode_sequencer_if bIf ();

  microcode_sequencer #(.HALT_MODE(1'b0)) dutA (.i_nclk(clk), .i_resetN(rstN), .bus(aIf.slave));
  microcode_sequencer #(.HALT_MODE(1'b1)) dutB (.i_nclk(clk), .i_resetN(rstN), .bus(bIf.slave));

  // ROM: finish bit low when step equals finAt (finAt=8 never finishes)
  function automatic logic [23:0] romWord(input logic [14:0] addr, input logic [3:0] finAt);
    logic finN;
    finN = ({1'b0, addr[2:0]} != finAt);
    return {3'b010, finN, 5'b10110, addr ^ 15'h2D4B};
  endfunction

  always_comb aIf.i_decodeData = romWord(aIf.o_decodeAddr, fin);
  always_comb bIf.i_decodeData = romWord(bIf.o_decodeAddr, fin);

  function automatic vec_t mk(input int sel, input int r, input int h, input int s, input int q,
                              input int en, input int fn, input int opc, input int flg,
                              input int eS, input int eF, input int eI, input int eH,
                              input int eA, input int eX);
    vec_t v;
    v.sel = 1'(sel); v.rstN = 1'(r); v.halt = 1'(h); v.step1 = 1'(s); v.irq = 1'(q);
    v.irqEn = 1'(en); v.fin = 4'(fn); v.opc = 8'(opc); v.flg = 4'(flg);
    v.eStep = 3'(eS); v.eFlags = 4'(eF); v.eInstr = 8'(eI);
    v.eHalted = 1'(eH); v.eAck = 1'(eA); v.eFault = 1'(eX);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    exp_t e, g;
    logic [23:0] rw;
    @(negedge clk);
    rstN = v.rstN;
    fin  = v.fin;
    aIf.i_halt = v.halt;  aIf.i_singleStep = v.step1; aIf.i_irq = v.irq;
    aIf.i_irqEnable = v.irqEn; aIf.i_instrCode = v.opc; aIf.i_flags = v.flg;
    bIf.i_halt = v.halt;  bIf.i_singleStep = v.step1; bIf.i_irq = v.irq;
    bIf.i_irqEnable = v.irqEn; bIf.i_instrCode = v.opc; bIf.i_flags = v.flg;
    e.sel    = v.sel;
    e.addr   = {v.eFlags, v.eInstr, v.eStep};
    e.status = {v.eHalted, v.eAck, v.eFault, v.eInstr[0], v.eInstr[2:1], v.eStep};
    rw       = romWord(e.addr, v.fin);
    e.strobe = v.eFault ? {1'b1, 21'h1FFFFF} : {rw[20], rw[20:0]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel) begin
      g.addr   = bIf.o_decodeAddr;
      g.status = {bIf.o_halted, bIf.o_irqAck, bIf.o_fault, bIf.o_aluSub, bIf.o_aluOp, bIf.o_dbgStep};
      g.strobe = {bIf.o_instrFinishedN, bIf.o_ctrl};
    end else begin
      g.addr   = aIf.o_decodeAddr;
      g.status = {aIf.o_halted, aIf.o_irqAck, aIf.o_fault, aIf.o_aluSub, aIf.o_aluOp, aIf.o_dbgStep};
      g.strobe = {aIf.o_instrFinishedN, aIf.o_ctrl};
    end
    check("addr",   idx, 32'(g.addr),   32'(e.addr));
    check("status", idx, 32'(g.status), 32'(e.status));
    check("strobe", idx, 32'(g.strobe), 32'(e.strobe));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    aIf.i_halt = 1'b0; aIf.i_singleStep = 1'b0; aIf.i_irq = 1'b0; aIf.i_irqEnable = 1'b0;
    aIf.i_instrCode = 8'h00; aIf.i_flags = 4'h0;
    bIf.i_halt = 1'b0; bIf.i_singleStep = 1'b0; bIf.i_irq = 1'b0; bIf.i_irqEnable = 1'b0;
    bIf.i_instrCode = 8'h00; bIf.i_flags = 4'h0;

    //                 sel r h s q en fin opc   flg   eS eF   eI    H A F
    // Reset mid-instruction
    vecs.push_back(mk(0, 0,0,0,0,0, 8, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5, k, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 0,0,0,0,0, 8, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    // ROM finish at step 3, then a new opcode is picked up
    vecs.push_back(mk(0, 1,0,0,0,0, 3, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 3, 'h12, 'h5,  2, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 3, 'h12, 'h5,  3, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 3, 'h12, 'h5,  0, 'h0, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 3, 'h34, 'hA,  1, 'hA, 'h34, 0,0,0));
    // Immediate halt with one single-step
    vecs.push_back(mk(0, 0,0,0,0,0, 8, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5,  2, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,1,0,0,0, 8, 'h12, 'h5,  2, 'h5, 'h12, 1,0,0));
    vecs.push_back(mk(0, 1,1,1,0,0, 8, 'h12, 'h5,  3, 'h5, 'h12, 1,0,0));
    vecs.push_back(mk(0, 1,1,0,0,0, 8, 'h12, 'h5,  3, 'h5, 'h12, 1,0,0));
    vecs.push_back(mk(0, 1,1,0,0,0, 8, 'h12, 'h5,  3, 'h5, 'h12, 1,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5,  3, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5,  4, 'h5, 'h12, 0,0,0));
    // Boundary-aligned halt (second instance)
    vecs.push_back(mk(1, 0,0,0,0,0, 3, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    vecs.push_back(mk(1, 1,0,0,0,0, 3, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(1, 1,1,0,0,0, 3, 'h12, 'h5,  2, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(1, 1,1,0,0,0, 3, 'h12, 'h5,  3, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(1, 1,1,0,0,0, 3, 'h12, 'h5,  0, 'h0, 'h12, 1,0,0));
    vecs.push_back(mk(1, 1,1,0,0,0, 3, 'h12, 'h5,  0, 'h0, 'h12, 1,0,0));
    vecs.push_back(mk(1, 1,0,0,0,0, 3, 'h12, 'h5,  0, 'h0, 'h12, 0,0,0));
    vecs.push_back(mk(1, 1,0,0,0,0, 3, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    // Interrupt entry: one-cycle request, ack after finish, IRQ opcode, then normal opcode
    vecs.push_back(mk(0, 0,0,0,0,1, 2, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,1,1, 2, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  2, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  0, 'h0, 'h12, 0,1,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  1, 'h5, 'hFF, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  2, 'h5, 'hFF, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  0, 'h0, 'hFF, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,1, 2, 'h12, 'h5,  1, 'h5, 'h12, 0,0,0));
    // Step overflow trap; held through new inputs and a ROM finish, cleared by reset
    vecs.push_back(mk(0, 0,0,0,0,0, 8, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5, k, 'h5, 'h12, 0,0,0));
    vecs.push_back(mk(0, 1,0,0,0,0, 8, 'h12, 'h5,  7, 'h5, 'h12, 0,0,1));
    vecs.push_back(mk(0, 1,1,0,0,0, 7, 'h56, 'hF,  7, 'h5, 'h12, 0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0, 8, 'h12, 'h5,  0, 'h0, 'h00, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

    // Request arriving while disabled stays pending across a boundary, taken once enabled
    applyVec(mk(0, 0,0,0,0,0, 1, 'h12, 'h5, 0, 'h0, 'h00, 0,0,0), 100);
    applyVec(mk(0, 1,0,0,1,0, 1, 'h12, 'h5, 1, 'h5, 'h12, 0,0,0), 101);
    applyVec(mk(0, 1,0,0,0,0, 1, 'h12, 'h5, 0, 'h0, 'h12, 0,0,0), 102);
    applyVec(mk(0, 1,0,0,0,1, 1, 'h12, 'h5, 1, 'h5, 'h12, 0,0,0), 103);
    applyVec(mk(0, 1,0,0,0,1, 1, 'h12, 'h5, 0, 'h0, 'h12, 0,1,0), 104);
    applyVec(mk(0, 1,0,0,0,1, 1, 'h12, 'h5, 1, 'h5, 'hFF, 0,0,0), 105);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
